// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter.
//   arb_state_t : access sequencing states
//   REQ_I/REQ_D : requester identity encoding used for the latched owner
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
package sram_arb_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 32;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/sram_grant_sel.sv
// Combinational grant selection between the instruction and data sides.
// Ports:
//   i_valid, d_valid : pending requests
//   streak           : consecutive data grants made while an instruction was waiting
//   gnt_i, gnt_d     : one-hot grant (both low when nothing is valid)
module sram_grant_sel
    import sram_arb_pkg::*;
#(
    parameter int D_STREAK_MAX = 4,
    parameter int STREAK_W     = 3
) (
    input  logic                i_valid,
    input  logic                d_valid,
    input  logic [STREAK_W-1:0] streak,
    output logic                gnt_i,
    output logic                gnt_d
);

    logic streak_full;

    always_comb begin
        streak_full = (streak == STREAK_W'(D_STREAK_MAX));
        // Data has priority unless it has starved the instruction side long enough.
        gnt_d       = d_valid & ~(i_valid & streak_full);
        gnt_i       = i_valid & ~gnt_d;
    end

endmodule

// File: rtl/base_sram_arbiter.sv
// Shares one SRAM port between instruction fetch and data access.
// Accesses are serialised; writes get a setup and a hold cycle around the
// WAIT_CYCLES-long access window. A one-cycle response pulse goes back to
// the side that owned the access.
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   i_req_* / i_resp_*           : instruction read request / response
//   d_req_* / d_resp_*           : data read/write request / response
//   sram_addr/din/en/we/wmask    : registered drive to the RAM wrapper
//   sram_dout                    : combinational read data from the wrapper
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | port free, arbitrating, all sram_* driven to 0
// ST_SETUP  | write address/data/mask presented, we low
// ST_ACCESS | access window, WAIT_CYCLES long, we = latched we
// ST_HOLD   | write fields held with we low before release
module base_sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int WAIT_CYCLES  = 2,
    parameter int D_STREAK_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_resp_valid,
    output logic [DATA_W-1:0] i_resp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_we,
    input  logic [DATA_W-1:0] d_req_wdata,
    input  logic [3:0]        d_req_wmask,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    output logic              sram_en,
    output logic              sram_we,
    output logic [3:0]        sram_wmask,
    input  logic [DATA_W-1:0] sram_dout
);

    localparam int CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int STREAK_W = (D_STREAK_MAX > 0) ? $clog2(D_STREAK_MAX + 1) : 1;

    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $error("base_sram_arbiter: WAIT_CYCLES must be at least 1");
    end

    arb_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [3:0]          mask_q, mask_d;

    logic                i_resp_valid_q, i_resp_valid_d;
    logic [DATA_W-1:0]   i_resp_data_q, i_resp_data_d;
    logic                d_resp_valid_q, d_resp_valid_d;
    logic [DATA_W-1:0]   d_resp_data_q, d_resp_data_d;

    logic                sram_en_q, sram_en_d;
    logic                sram_we_q, sram_we_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]   sram_din_q, sram_din_d;
    logic [3:0]          sram_wmask_q, sram_wmask_d;

    logic                gnt_i, gnt_d;
    logic                is_idle;
    logic                cnt_last;

    sram_grant_sel #(
        .D_STREAK_MAX (D_STREAK_MAX),
        .STREAK_W     (STREAK_W)
    ) u_grant_sel (
        .i_valid (i_req_valid),
        .d_valid (d_req_valid),
        .streak  (streak_q),
        .gnt_i   (gnt_i),
        .gnt_d   (gnt_d)
    );

    assign is_idle     = (state_q == ST_IDLE);
    assign cnt_last    = (cnt_q == CNT_W'(WAIT_CYCLES - 1));
    // Ready is suppressed during reset so nothing transfers into an aborted state.
    assign i_req_ready = is_idle & ~reset & gnt_i;
    assign d_req_ready = is_idle & ~reset & gnt_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        streak_d       = streak_q;
        owner_d        = owner_q;
        we_d           = we_q;
        addr_d         = addr_q;
        din_d          = din_q;
        mask_d         = mask_q;
        i_resp_valid_d = 1'b0;
        d_resp_valid_d = 1'b0;
        i_resp_data_d  = i_resp_data_q;
        d_resp_data_d  = d_resp_data_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (d_req_ready) begin
                    owner_d = REQ_D;
                    we_d    = d_req_we;
                    addr_d  = d_req_addr;
                    din_d   = d_req_we ? d_req_wdata : '0;
                    mask_d  = d_req_we ? d_req_wmask : 4'hF;
                    state_d = d_req_we ? ST_SETUP : ST_ACCESS;
                    if (i_req_valid && (streak_q != STREAK_W'(D_STREAK_MAX))) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (i_req_ready) begin
                    owner_d  = REQ_I;
                    we_d     = 1'b0;
                    addr_d   = i_req_addr;
                    din_d    = '0;
                    mask_d   = 4'hF;
                    state_d  = ST_ACCESS;
                    streak_d = '0;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (we_q) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                        if (owner_q == REQ_D) begin
                            d_resp_valid_d = 1'b1;
                            d_resp_data_d  = sram_dout;
                        end else begin
                            i_resp_valid_d = 1'b1;
                            i_resp_data_d  = sram_dout;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                // Only the data side can write, so the acknowledge always goes there.
                state_d        = ST_IDLE;
                d_resp_valid_d = 1'b1;
                d_resp_data_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // SRAM drive is registered from the next state so it lines up with the state itself.
        sram_en_d    = (state_d != ST_IDLE);
        sram_we_d    = (state_d == ST_ACCESS) & we_d;
        sram_addr_d  = sram_en_d ? addr_d : '0;
        sram_din_d   = sram_en_d ? din_d  : '0;
        sram_wmask_d = sram_en_d ? mask_d : 4'h0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            streak_q       <= '0;
            owner_q        <= REQ_I;
            we_q           <= 1'b0;
            addr_q         <= '0;
            din_q          <= '0;
            mask_q         <= 4'h0;
            i_resp_valid_q <= 1'b0;
            i_resp_data_q  <= '0;
            d_resp_valid_q <= 1'b0;
            d_resp_data_q  <= '0;
            sram_en_q      <= 1'b0;
            sram_we_q      <= 1'b0;
            sram_addr_q    <= '0;
            sram_din_q     <= '0;
            sram_wmask_q   <= 4'h0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            streak_q       <= streak_d;
            owner_q        <= owner_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            din_q          <= din_d;
            mask_q         <= mask_d;
            i_resp_valid_q <= i_resp_valid_d;
            i_resp_data_q  <= i_resp_data_d;
            d_resp_valid_q <= d_resp_valid_d;
            d_resp_data_q  <= d_resp_data_d;
            sram_en_q      <= sram_en_d;
            sram_we_q      <= sram_we_d;
            sram_addr_q    <= sram_addr_d;
            sram_din_q     <= sram_din_d;
            sram_wmask_q   <= sram_wmask_d;
        end
    end

    assign i_resp_valid = i_resp_valid_q;
    assign i_resp_data  = i_resp_data_q;
    assign d_resp_valid = d_resp_valid_q;
    assign d_resp_data  = d_resp_data_q;
    assign sram_en      = sram_en_q;
    assign sram_we      = sram_we_q;
    assign sram_addr    = sram_addr_q;
    assign sram_din     = sram_din_q;
    assign sram_wmask   = sram_wmask_q;

endmodule

// File: doc/base_sram_arbiter.md
# base_sram_arbiter

Shares one SRAM port (the `io_sram_*` interface presented by the pass-through RAM wrapper) between the core's instruction-fetch side and its data side. The block serialises accesses, holds address, data and strobes stable for a programmable number of cycles, and sequences writes with setup and hold cycles. It returns a one-cycle response pulse to the winning requester. It sits between the core and the base RAM wrapper, in the `clock` domain.

## Interface

**Parameters**
- `ADDR_W`, 20, SRAM word-address width.
- `DATA_W`, 32, data width.
- `WAIT_CYCLES`, 2, number of cycles in ACCESS (must be ≥1).
- `D_STREAK_MAX`, 4, maximum number of consecutive data grants allowed while an instruction request is pending.

**Ports** (clock and reset first)
- `clock`, in, 1, the single clock.
- `reset`, in, 1, synchronous, active-high reset.
- `i_req_valid`, in, 1, instruction read request.
- `i_req_ready`, out, 1, instruction request accepted this cycle.
- `i_req_addr`, in, ADDR_W, instruction word address.
- `i_resp_valid`, out, 1, one-cycle pulse; `i_resp_data` is valid in that cycle.
- `i_resp_data`, out, DATA_W, read data.
- `d_req_valid`, in, 1, data request.
- `d_req_ready`, out, 1, data request accepted this cycle.
- `d_req_addr`, in, ADDR_W, data word address.
- `d_req_we`, in, 1, 1 means write.
- `d_req_wdata`, in, DATA_W, write data.
- `d_req_wmask`, in, 4, byte enables, active high.
- `d_resp_valid`, out, 1, one-cycle pulse; read data, or the write acknowledge.
- `d_resp_data`, out, DATA_W, read data; 0 for writes.
- `sram_addr`, out, ADDR_W, address to the wrapper.
- `sram_din`, out, DATA_W, write data to the wrapper.
- `sram_en`, out, 1, chip enable.
- `sram_we`, out, 1, write enable.
- `sram_wmask`, out, 4, byte mask.
- `sram_dout`, in, DATA_W, read data from the wrapper; combinational from the SRAM.

## Operation

**State machine:** IDLE, SETUP, ACCESS, HOLD.

**Transitions**
- Read: IDLE → ACCESS → IDLE.
- Write: IDLE → SETUP → ACCESS → HOLD → IDLE.

**Request handshake**
- Ready is high only in IDLE, combinationally from the valid inputs.
- At most one ready is high per cycle.
- A request transfers on valid & ready.
- On transfer, the block latches the address, we, wdata, wmask and the requester's identity.
- A requester holds its request fields stable until ready.

**Grant rule in IDLE**
- Only one valid: that requester wins.
- Both valid: data wins, unless `streak == D_STREAK_MAX`, in which case instruction wins.
- `streak` increments (saturating) on a data grant made while `i_req_valid` is high.
- `streak` clears on any instruction grant.

**SRAM outputs per state**
- IDLE: en=0, we=0, wmask=0, addr=0, din=0.
- SETUP: en=1, we=0, latched addr/din/wmask.
- ACCESS: en=1, we=latched we, latched fields.
- HOLD: en=1, we=0, latched fields.
- A read drives wmask=4'hF.

**ACCESS counter**
- Counts from 0 to WAIT_CYCLES-1.
- On the last ACCESS cycle of a read, `sram_dout` is registered into the response register of the owning side.

**Response**
- The owning side's `*_resp_valid` pulses for one cycle, in the cycle after leaving ACCESS (read) or HOLD (write).
- The response data stays stable until the next response to that side.

## Timing

**Read**
- Handshake at cycle T.
- ACCESS spans T+1 … T+WAIT_CYCLES.
- resp_valid is high at T+WAIT_CYCLES+1.
- ready is available again at T+WAIT_CYCLES+1, so back-to-back reads take WAIT_CYCLES+1 cycles each.

**Write**
- Handshake at cycle T.
- SETUP at T+1.
- ACCESS spans T+2 … T+WAIT_CYCLES+1.
- HOLD at T+WAIT_CYCLES+2.
- d_resp_valid is high at T+WAIT_CYCLES+3.

**Reset**
- Values: state=IDLE, counter=0, streak=0.
- All resp_valid=0 and all resp_data=0.
- All sram_* outputs = 0.
- Reset during any state aborts the access immediately; no response is issued.
- Both ready outputs are 0 in the reset cycle.

**Simultaneous events**
- A new request that is valid in the same cycle as a resp_valid pulse is grantable in that cycle, because the state is already IDLE.
- A valid that is asserted during a busy period is held by the requester and is arbitrated on return to IDLE.

## Structure

- Package `sram_arb_pkg` holds:
  - the state enum;
  - ADDR_W and DATA_W defaults;
  - the requester-ID encoding (REQ_I=0, REQ_D=1).
- One sub-module, `sram_grant_sel`: purely combinational grant selection that takes both valids and streak and produces one-hot grants.
- The FSM, counters and latches live in the top block.
- Elaboration fails if WAIT_CYCLES < 1.

## Test plan

All scenarios use WAIT_CYCLES=2.

1. **Single read.** I-read to addr 0x00010 with sram_dout=0xDEADBEEF.
   - Required: en=1 for 2 cycles with we=0.
   - Required: i_resp_valid at T+3 with data 0xDEADBEEF.
   - Required: d_resp_valid stays 0.
2. **Single write.** D-write to addr 0x00020, wdata 0x12345678, wmask 4'b0011.
   - Required: we=0 in SETUP, we=1 for exactly 2 cycles, we=0 in HOLD.
   - Required: addr and din stable in all 4 cycles.
   - Required: d_resp_valid at T+5 with data 0.
3. **Contention.** Both sides valid continuously with D_STREAK_MAX=4.
   - Required grant order: D,D,D,D,I,D,D,D,D,I…
   - Required: never two readies in the same cycle.
4. **Back-to-back reads.** Successive I-reads to 0x0, 0x1, 0x2.
   - Required: handshakes every 3 cycles.
   - Required: responses return in order with the matching data.
5. **Reset mid-operation.** Reset asserted in the second ACCESS cycle of a write.
   - Required next cycle: all sram_* = 0 and state IDLE.
   - Required: no resp_valid ever issued for the aborted write.
   - Required: a following read completes normally.
6. **Response/request overlap.** A D-read is pending while an I-read finishes.
   - Required: d_req_ready is high in the same cycle as i_resp_valid.
